// File: rtl/sram_like_slave_pkg.sv
// Shared sram-like interface widths, response-queue entry and byte-merge helper.
package sram_like_slave_pkg;

    localparam int SL_ADDR_W  = 32;
    localparam int SL_DATA_W  = 32;
    localparam int SL_WSTRB_W = 4;
    localparam int SL_SIZE_W  = 2;
    // Countdown field is fixed-width so the struct can live here; DATA_DELAY must fit in it.
    localparam int CD_W       = 8;

    typedef struct packed {
        logic [SL_DATA_W-1:0] data;
        logic [CD_W-1:0]      countdown;
    } resp_entry_t;

    function automatic logic [SL_DATA_W-1:0] merge_bytes(
        input logic [SL_DATA_W-1:0]  old_word,
        input logic [SL_DATA_W-1:0]  new_word,
        input logic [SL_WSTRB_W-1:0] strb
    );
        logic [SL_DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < SL_WSTRB_W; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_like_resp_fifo.sv
// In-order response queue; every valid entry counts down independently, only the head may leave.
module sram_like_resp_fifo
    import sram_like_slave_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  resp_entry_t          push_entry,
    input  logic                 pop,
    output logic                 full,
    output logic                 empty,
    output logic                 head_ready,
    output logic [SL_DATA_W-1:0] head_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    resp_entry_t      slot_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign full       = (count_r == CNT_W'(DEPTH));
    assign empty      = (count_r == '0);
    assign head_ready = valid_r[head_r] && (slot_r[head_r].countdown == '0);
    assign head_data  = slot_r[head_r].data;
    assign push_s     = push && !full;
    assign pop_s      = pop && head_ready;

    // Queue storage, pointers, occupancy and per-entry countdowns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_r[i] && (slot_r[i].countdown != '0)) begin
                    slot_r[i].countdown <= slot_r[i].countdown - CD_W'(1);
                end
            end
            if (pop_s) begin
                valid_r[head_r] <= 1'b0;
                head_r          <= ptr_next(head_r);
            end
            // The tail slot is never valid when a push is allowed, so it cannot clash with the countdown update.
            if (push_s) begin
                slot_r[tail_r]  <= push_entry;
                valid_r[tail_r] <= 1'b1;
                tail_r          <= ptr_next(tail_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_slave.sv
// sram-like responder: word memory, address-handshake delay and delayed in-order responses.
module sram_like_slave
    import sram_like_slave_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int ADDR_DELAY = 0,
    parameter int DATA_DELAY = 1,
    parameter int MAX_OUT    = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req,
    input  logic                  wr,
    input  logic [SL_SIZE_W-1:0]  size,
    input  logic [SL_WSTRB_W-1:0] wstrb,
    input  logic [SL_ADDR_W-1:0]  addr,
    input  logic [SL_DATA_W-1:0]  wdata,
    output logic                  addr_ok,
    output logic                  data_ok,
    output logic [SL_DATA_W-1:0]  rdata
);

    localparam int HOLD_W = (ADDR_DELAY > 0) ? $clog2(ADDR_DELAY + 1) : 1;

    logic [SL_DATA_W-1:0] mem_r [2**ADDR_W];
    logic [HOLD_W-1:0]    hold_r;
    logic [ADDR_W-1:0]    word_idx_s;
    logic                 accept_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 head_ready_s;
    logic [SL_DATA_W-1:0] head_data_s;
    resp_entry_t          push_entry_s;
    logic                 unused_s;

    assign word_idx_s = addr[ADDR_W+1:2];
    // resetn gates addr_ok so it drops asynchronously even with ADDR_DELAY=0.
    assign addr_ok    = resetn && req && (hold_r == HOLD_W'(ADDR_DELAY)) && !fifo_full_s;
    assign accept_s   = req && addr_ok;
    assign data_ok    = head_ready_s;
    assign rdata      = head_ready_s ? head_data_s : {SL_DATA_W{1'b0}};
    assign unused_s   = ^{size, addr[1:0], addr[SL_ADDR_W-1:ADDR_W+2], fifo_empty_s};

    // Queue entry for the request being presented: read data sampled now, zero for writes.
    always_comb begin
        push_entry_s = '0;
        if (wr) begin
            push_entry_s.data = {SL_DATA_W{1'b0}};
        end else begin
            push_entry_s.data = mem_r[word_idx_s];
        end
        push_entry_s.countdown = CD_W'(DATA_DELAY);
    end

    // Hold counter: consecutive unaccepted req cycles, saturating at ADDR_DELAY.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_r <= '0;
        end else if (!req || accept_s) begin
            hold_r <= '0;
        end else if (hold_r != HOLD_W'(ADDR_DELAY)) begin
            hold_r <= hold_r + HOLD_W'(1);
        end else begin
            hold_r <= hold_r;
        end
    end

    // Backing memory, byte-masked writes on acceptance; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept_s && wr) begin
            mem_r[word_idx_s] <= merge_bytes(mem_r[word_idx_s], wdata, wstrb);
        end
    end

    sram_like_resp_fifo #(
        .DEPTH (MAX_OUT)
    ) u_resp_fifo (
        .clk        (clk),
        .rst_n      (resetn),
        .push       (accept_s),
        .push_entry (push_entry_s),
        .pop        (head_ready_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .head_ready (head_ready_s),
        .head_data  (head_data_s)
    );

endmodule

// File: tb/tb_sram_like_slave.sv
// Scoreboard bench for sram_like_slave: two configurations, directed plus random traffic.
module tb_sram_like_slave;

    localparam int AW = 6;
    localparam logic [31:0] IDX_MASK = 32'((1 << AW) - 1);

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit done [2];

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int AD = (g == 0) ? 0 : 2;
        localparam int DD = (g == 0) ? 2 : 3;
        localparam int MO = (g == 0) ? 3 : 2;

        logic        resetn;
        logic        req;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] rdata;

        sram_like_slave #(
            .ADDR_W     (AW),
            .ADDR_DELAY (AD),
            .DATA_DELAY (DD),
            .MAX_OUT    (MO)
        ) dut (
            .clk     (clk),
            .resetn  (resetn),
            .req     (req),
            .wr      (wr),
            .size    (size),
            .wstrb   (wstrb),
            .addr    (addr),
            .wdata   (wdata),
            .addr_ok (addr_ok),
            .data_ok (data_ok),
            .rdata   (rdata)
        );

        int          cyc = 0;
        exp_t        exp_q [$];
        int          pend_q [$];
        logic [31:0] mem_m [2**AW];
        int          hold_m = 0;
        int          last_resp = -1;
        bit          acc_m = 1'b0;

        always @(posedge clk) cyc <= cyc + 1;

        task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
            n_checks++;
            if (act !== expv) begin
                n_fail++;
                $display("FAIL cfg%0d %s at cycle %0d: got %h expected %h", g, name, cyc, act, expv);
            end
        endtask

        // Reference model evaluated at mid-cycle: outstanding count is responses not yet due.
        task automatic model_cycle();
            int   idx;
            int   resp;
            logic exp_ok;
            while (pend_q.size() > 0 && pend_q[0] < cyc) pend_q.delete(0);
            exp_ok = req && (hold_m >= AD) && (pend_q.size() < MO);
            check("addr_ok", 32'(addr_ok), 32'(exp_ok));
            acc_m = exp_ok;
            if (exp_ok) begin
                idx  = int'((addr >> 2) & IDX_MASK);
                resp = cyc + 1 + DD;
                if (resp <= last_resp) resp = last_resp + 1;
                last_resp = resp;
                pend_q.push_back(resp);
                if (wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wstrb[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
                    end
                    exp_q.push_back('{32'd0, resp});
                end else begin
                    exp_q.push_back('{mem_m[idx], resp});
                end
                hold_m = 0;
            end else if (req) begin
                hold_m++;
            end else begin
                hold_m = 0;
            end
        endtask

        task automatic drive_cycle(input logic r, input logic w, input logic [31:0] a,
                                   input logic [31:0] d, input logic [3:0] s);
            req = r; wr = w; addr = a; wdata = d; wstrb = s; size = 2'd2;
            @(negedge clk);
            model_cycle();
            @(posedge clk);
            #1;
        endtask

        task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
            int n = 0;
            do begin
                drive_cycle(1'b1, w, a, d, s);
                n++;
            end while (!acc_m && n < 40);
            if (!acc_m) check("accept_timeout", 32'd0, 32'd1);
        endtask

        task automatic idle(input int n);
            for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        endtask

        task automatic do_reset(input logic hold_req);
            req = hold_req; wr = 1'b0; addr = 32'd0; wdata = 32'd0; wstrb = 4'd0; size = 2'd2;
            resetn = 1'b0;
            #2;
            check("rst_addr_ok", 32'(addr_ok), 32'd0);
            check("rst_data_ok", 32'(data_ok), 32'd0);
            check("rst_rdata", rdata, 32'd0);
            exp_q.delete();
            pend_q.delete();
            hold_m = 0;
            last_resp = -1;
            @(posedge clk);
            #1;
            resetn = 1'b1;
        endtask

        // Monitor: pops the scoreboard whenever a response appears and flags late or spurious ones.
        always @(negedge clk) begin
            exp_t e;
            if (resetn === 1'b1) begin
                if (data_ok === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_data_ok", 32'(data_ok), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rdata", rdata, e.data);
                        check("resp_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end else begin
                    check("rdata_idle", rdata, 32'd0);
                    if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                        check("missing_data_ok", 32'(data_ok), 32'd1);
                        exp_q.delete(0);
                    end
                end
            end
        end

        initial begin
            resetn = 1'b0; req = 1'b1; wr = 1'b0; addr = 32'd0; wdata = 32'd0; wstrb = 4'd0; size = 2'd2;
            @(posedge clk);
            #1;
            do_reset(1'b1);
            for (int i = 0; i < 2**AW; i++) xfer(1'b1, 32'(i * 4), $urandom, 4'hF);
            idle(8);
            xfer(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
            idle(6);
            xfer(1'b0, 32'h100, 32'd0, 4'd0);
            idle(6);
            xfer(1'b1, 32'h100, 32'h0000AB00, 4'h2);
            xfer(1'b0, 32'h100, 32'd0, 4'd0);
            xfer(1'b0, 32'h100 | (32'd1 << (AW + 2)), 32'd0, 4'd0);
            idle(8);
            for (int i = 0; i < 3; i++) xfer(1'b0, 32'(i * 4 + 8), 32'd0, 4'd0);
            idle(10);
            drive_cycle(1'b1, 1'b0, 32'h40, 32'd0, 4'd0);
            idle(1);
            xfer(1'b0, 32'h44, 32'd0, 4'd0);
            idle(8);
            xfer(1'b0, 32'h10, 32'd0, 4'd0);
            xfer(1'b0, 32'h14, 32'd0, 4'd0);
            do_reset(1'b0);
            idle(10);
            for (int i = 0; i < 250; i++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 3) begin
                    do_reset(1'b0);
                end else if (r < 10) begin
                    drive_cycle(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
                    idle(1);
                end else if (r < 25) begin
                    idle($urandom_range(1, 4));
                end else begin
                    xfer(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
                end
            end
            idle(20);
            check("drain", 32'(exp_q.size()), 32'd0);
            done[g] = 1'b1;
        end
    end

    initial begin
        int waited = 0;
        while (!(done[0] && done[1]) && waited < 60000) begin
            @(posedge clk);
            waited++;
        end
        if (!(done[0] && done[1])) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_timeout: got %0d cycles without completion, required completion", waited);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
